// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset domain sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_ASSERT  = 2'd3
    } seq_state_t;

    // The counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int hold, input int delay);
        int m;
        m = (hold > delay) ? hold : delay;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with a terminal-count flag, shared by every timed phase.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] tc_value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge CLOCK) begin
        if (RESET || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == tc_value);

endmodule

// File: rtl/reset_domain_sequencer.sv
// Releases reset domains upward after a hold period and asserts them downward
// on any reset request, recording the cause of every request.
module reset_domain_sequencer
    import reset_seq_pkg::*;
#(
    parameter int P_DOMAINS = 4,
    parameter int P_REQS    = 3,
    parameter int P_HOLD    = 16,
    parameter int P_DELAY   = 100
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [P_REQS-1:0]    RST_REQ,
    input  logic                 CAUSE_CLR,
    output logic [P_DOMAINS-1:0] DOMAIN_RESET_N,
    output logic [P_REQS-1:0]    RST_CAUSE,
    output logic                 SEQ_DONE,
    output logic                 BUSY,
    output seq_state_t           DBG_STATE
);

    localparam int CW = cnt_width(P_HOLD, P_DELAY);
    localparam int IW = (P_DOMAINS > 1) ? $clog2(P_DOMAINS) : 1;
    localparam logic [CW-1:0] HOLD_TC  = CW'(P_HOLD - 1);
    localparam logic [CW-1:0] DELAY_TC = CW'(P_DELAY - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(P_DOMAINS - 1);

    seq_state_t           state_q, state_d;
    logic [IW-1:0]        index_q, index_d;
    logic [P_DOMAINS-1:0] drn_q, drn_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 asrt_last_q, asrt_last_d;
    logic                 pend_q, pend_d;
    logic [P_REQS-1:0]    cause_q;

    logic                 req_any;
    logic                 start_asrt;
    logic                 tmr_load;
    logic                 tmr_en;
    logic                 tmr_tc;
    logic [CW-1:0]        tmr_tc_value;
    logic [IW-1:0]        idx_up;
    logic [IW-1:0]        idx_dn;

    assign req_any = |RST_REQ;
    assign idx_up  = index_q + 1'b1;
    assign idx_dn  = index_q - 1'b1;

    seq_timer #(.W(CW)) u_timer (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (tmr_load),
        .en       (tmr_en),
        .tc_value (tmr_tc_value),
        .tc       (tmr_tc)
    );

    // index_q is the highest released domain in RELEASE/RUN and the next
    // domain to assert in ASSERT; asrt_last_q marks that domain 0 is down.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        drn_d        = drn_q;
        done_d       = done_q;
        asrt_last_d  = asrt_last_q;
        pend_d       = pend_q;
        start_asrt   = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_tc_value = (state_q == S_HOLD) ? HOLD_TC : DELAY_TC;

        case (state_q)
            S_HOLD: begin
                if (req_any) begin
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    drn_d[0] = 1'b1;
                    index_d  = '0;
                    if (P_DOMAINS == 1) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_RELEASE: begin
                // The final release always completes; a coincident request is
                // remembered so the shutdown starts on the following edge.
                if (tmr_tc && (idx_up == IDX_TOP)) begin
                    tmr_load      = 1'b1;
                    drn_d[idx_up] = 1'b1;
                    index_d       = idx_up;
                    state_d       = S_RUN;
                    done_d        = 1'b1;
                    pend_d        = req_any;
                end else if (req_any) begin
                    start_asrt = 1'b1;
                end else if (tmr_tc) begin
                    tmr_load      = 1'b1;
                    drn_d[idx_up] = 1'b1;
                    index_d       = idx_up;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_RUN: begin
                if (req_any || pend_q) begin
                    start_asrt = 1'b1;
                    pend_d     = 1'b0;
                    done_d     = 1'b0;
                end
            end
            S_ASSERT: begin
                if (asrt_last_q) begin
                    state_d     = S_HOLD;
                    tmr_load    = 1'b1;
                    asrt_last_d = 1'b0;
                end else if (tmr_tc) begin
                    tmr_load       = 1'b1;
                    drn_d[index_q] = 1'b0;
                    if (index_q == '0) begin
                        asrt_last_d = 1'b1;
                    end else begin
                        index_d = idx_dn;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        if (start_asrt) begin
            drn_d[index_q] = 1'b0;
            tmr_load       = 1'b1;
            tmr_en         = 1'b0;
            state_d        = S_ASSERT;
            if (index_q == '0) begin
                asrt_last_d = 1'b1;
            end else begin
                asrt_last_d = 1'b0;
                index_d     = idx_dn;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_HOLD;
            index_q     <= '0;
            drn_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            asrt_last_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            drn_q       <= drn_d;
            done_q      <= done_d;
            busy_q      <= (state_d != S_RUN);
            asrt_last_q <= asrt_last_d;
            pend_q      <= pend_d;
        end
    end

    // A set on the same cycle as a clear keeps that bit set.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cause_q <= '0;
        end else begin
            cause_q <= (cause_q & ~{P_REQS{CAUSE_CLR}}) | RST_REQ;
        end
    end

    assign DOMAIN_RESET_N = drn_q;
    assign RST_CAUSE      = cause_q;
    assign SEQ_DONE       = done_q;
    assign BUSY           = busy_q;
    assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Directed scenarios for the reset domain sequencer; domain output changes are
// checked against a queue of expected (cycle, value) events.
module tb_reset_domain_sequencer;
    import reset_seq_pkg::*;

    localparam int ND = 4;
    localparam int NR = 3;
    localparam int EW = 37;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic          clr;
    logic [ND-1:0] drn;
    logic [NR-1:0] cause;
    logic          done;
    logic          busy;
    seq_state_t    dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [4:0] prev_obs;
    logic [EW-1:0] exp_q[$];

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_domain_sequencer #(
        .P_DOMAINS (4),
        .P_REQS    (3),
        .P_HOLD    (16),
        .P_DELAY   (100)
    ) dut (
        .CLOCK          (clk),
        .RESET          (rst),
        .RST_REQ        (req),
        .CAUSE_CLR      (clr),
        .DOMAIN_RESET_N (drn),
        .RST_CAUSE      (cause),
        .SEQ_DONE       (done),
        .BUSY           (busy),
        .DBG_STATE      (dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic [3:0] d, input logic dn);
        logic [31:0] cc;
        cc = c;
        exp_q.push_back({cc, d, dn});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: every change of {DOMAIN_RESET_N, SEQ_DONE} must match the next expected event
    always @(negedge clk) begin
        logic [4:0]    cur;
        logic [EW-1:0] e;
        logic [31:0]   cc;
        cur = {drn, done};
        cc  = cyc;
        if (mon_en && (cur !== prev_obs)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_change: got drn=%b done=%b at cycle %0d, required no change",
                         cur[4:1], cur[0], cyc);
            end else begin
                e = exp_q.pop_front();
                if ((e[EW-1:5] !== cc) || (e[4:0] !== cur)) begin
                    n_errors++;
                    $display("FAIL domain_event: got drn=%b done=%b at cycle %0d, required drn=%b done=%b at cycle %0d",
                             cur[4:1], cur[0], cyc, e[4:1], e[0], e[EW-1:5]);
                end
            end
        end
        prev_obs = cur;
    end

    // driver
    initial begin
        int t;
        rst = 1'b1;
        req = '0;
        clr = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_drn",   32'(drn),   32'h0);
        check("reset_cause", 32'(cause), 32'h0);
        check("reset_busy",  32'(busy),  32'h1);
        check("reset_done",  32'(done),  32'h0);
        check("reset_state", 32'(dbg),   32'(S_HOLD));
        mon_en = 1'b1;

        // power-up
        t = cyc;
        rst = 1'b0;
        expect_ev(t + 16,  4'b0001, 1'b0);
        expect_ev(t + 116, 4'b0011, 1'b0);
        expect_ev(t + 216, 4'b0111, 1'b0);
        expect_ev(t + 316, 4'b1111, 1'b1);
        wait_until(t + 320);
        check("run_busy",  32'(busy),  32'h0);
        check("run_cause", 32'(cause), 32'h0);

        // one-cycle request from RUN
        t = cyc;
        req = 3'b010;
        expect_ev(t + 1,   4'b0111, 1'b0);
        expect_ev(t + 101, 4'b0011, 1'b0);
        expect_ev(t + 201, 4'b0001, 1'b0);
        expect_ev(t + 301, 4'b0000, 1'b0);
        expect_ev(t + 318, 4'b0001, 1'b0);
        expect_ev(t + 418, 4'b0011, 1'b0);
        expect_ev(t + 518, 4'b0111, 1'b0);
        expect_ev(t + 618, 4'b1111, 1'b1);
        @(negedge clk);
        req = '0;
        check("assert_busy",  32'(busy), 32'h1);
        check("assert_state", 32'(dbg),  32'(S_ASSERT));
        wait_until(t + 620);
        check("cause_after_req1", 32'(cause), 32'h2);
        check("rerun_busy",       32'(busy),  32'h0);

        // request held through ASSERT and into HOLD
        t = cyc;
        req = 3'b100;
        expect_ev(t + 1,   4'b0111, 1'b0);
        expect_ev(t + 101, 4'b0011, 1'b0);
        expect_ev(t + 201, 4'b0001, 1'b0);
        expect_ev(t + 301, 4'b0000, 1'b0);
        expect_ev(t + 368, 4'b0001, 1'b0);
        expect_ev(t + 468, 4'b0011, 1'b0);
        wait_until(t + 340);
        check("held_in_hold", 32'(dbg), 32'(S_HOLD));
        wait_until(t + 352);
        req = '0;
        wait_until(t + 470);

        // abort from RELEASE with a coincident cause clear
        check("cause_before_clr", 32'(cause), 32'h6);
        check("release_state",    32'(dbg),   32'(S_RELEASE));
        t = cyc;
        req = 3'b001;
        clr = 1'b1;
        expect_ev(t + 1,   4'b0001, 1'b0);
        expect_ev(t + 101, 4'b0000, 1'b0);
        expect_ev(t + 118, 4'b0001, 1'b0);
        expect_ev(t + 218, 4'b0011, 1'b0);
        expect_ev(t + 318, 4'b0111, 1'b0);
        @(negedge clk);
        req = '0;
        clr = 1'b0;
        check("cause_set_wins", 32'(cause), 32'h1);
        wait_until(t + 320);

        // RESET mid-release
        t = cyc;
        rst = 1'b1;
        expect_ev(t + 1, 4'b0000, 1'b0);
        @(negedge clk);
        check("midreset_drn",   32'(drn),   32'h0);
        check("midreset_cause", 32'(cause), 32'h0);
        check("midreset_busy",  32'(busy),  32'h1);
        check("midreset_done",  32'(done),  32'h0);
        repeat (2) @(negedge clk);
        t = cyc;
        rst = 1'b0;
        expect_ev(t + 16,  4'b0001, 1'b0);
        expect_ev(t + 116, 4'b0011, 1'b0);
        expect_ev(t + 216, 4'b0111, 1'b0);
        expect_ev(t + 316, 4'b1111, 1'b1);
        wait_until(t + 330);
        check("final_busy",  32'(busy), 32'h0);
        check("final_state", 32'(dbg),  32'(S_RUN));
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        // report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_domain_sequencer.md
# reset_domain_sequencer

Sequences the release and re-assertion of several downstream reset domains after power-on, and turns asynchronous reset requests (fault, watchdog, software) into an ordered shutdown/restart cycle. It sits directly after the power-on reset generator and replaces scattered per-domain reset logic in the power-sequencer design. Domains are released in ascending index order with a fixed spacing, and asserted in descending order. The block records the cause of every reset.

## Interface
- P_DOMAINS, 4: number of reset domains; must be at least 1.
- P_REQS, 3: number of reset-request inputs; must be at least 1.
- P_HOLD, 16: minimum cycles all domains stay in reset; must be at least 1.
- P_DELAY, 100: cycles between successive domain releases or assertions; must be at least 1.
- CLOCK  in  1  single system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- RST_REQ  in  P_REQS  level reset requests, synchronous to CLOCK.
- CAUSE_CLR  in  1  one-cycle pulse that clears RST_CAUSE.
- DOMAIN_RESET_N  out  P_DOMAINS  per-domain active-low resets; registered.
- RST_CAUSE  out  P_REQS  sticky record of requests seen since the last clear.
- SEQ_DONE  out  1  high while all domains are released.
- BUSY  out  1  high in every state except RUN.

## Operation
- States:
  - HOLD: all domains in reset; timing the hold period.
  - RELEASE: releasing domains upward.
  - RUN: all domains out of reset.
  - ASSERT: asserting domains downward.
- Reset behaviour:
  - While RESET is high: state = HOLD, counter = 0, index = 0.
  - Outputs during reset: DOMAIN_RESET_N = 0, RST_CAUSE = 0, SEQ_DONE = 0, BUSY = 1.
  - RESET mid-operation applies the same values on the next edge, from any state.
- HOLD:
  - The counter increments only when RST_REQ == 0; any set request bit reloads it to 0.
  - When the counter reaches P_HOLD-1: release DOMAIN_RESET_N[0], set index = 0, go to RELEASE.
- RELEASE:
  - Every P_DELAY cycles, release domain index+1.
  - When domain P_DOMAINS-1 is released: go to RUN and set SEQ_DONE = 1 in the same cycle.
  - If P_DOMAINS = 1: go HOLD→RUN directly.
- RUN:
  - Any RST_REQ bit high → ASSERT.
  - SEQ_DONE drops and the highest domain is asserted on the next edge.
- RELEASE abort:
  - Any RST_REQ bit high during RELEASE → ASSERT.
  - The highest currently released domain is asserted on the next edge.
- ASSERT:
  - After the first assertion, assert the next lower released domain every P_DELAY cycles.
  - One cycle after domain 0 is asserted, go to HOLD with counter = 0.
  - RST_REQ during ASSERT does not alter the sequence.
- RST_CAUSE:
  - Bit i sets on any cycle where RST_REQ[i] = 1 and RESET = 0.
  - CAUSE_CLR clears all bits.
  - If a set and a clear coincide, the set wins for that bit.
- Counter width: $clog2(max(P_HOLD, P_DELAY) + 1). No wrap-around is reachable, because the counter reloads at terminal count.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Request → first domain asserted: 1 cycle, from RUN or RELEASE.
- Power-up, with edge 0 defined as the first edge with RESET = 0 and RST_REQ = 0:
  - DOMAIN_RESET_N[0] rises after edge P_HOLD-1.
  - DOMAIN_RESET_N[i] rises exactly P_DELAY cycles after DOMAIN_RESET_N[i-1].
- Full power-up sequence length: P_HOLD + (P_DOMAINS-1)·P_DELAY cycles.
- Simultaneous events:
  - A request on the same edge as the last release: the release completes, then ASSERT starts next cycle.
  - A request on the HOLD terminal edge: the counter reloads and no release occurs.

## Structure
- Package reset_seq_pkg holds:
  - the state enum typedef (S_HOLD, S_RELEASE, S_RUN, S_ASSERT);
  - a function computing the counter width from P_HOLD and P_DELAY.
- Sub-module seq_timer is a loadable up-counter with a terminal-count flag. It is instantiated once and shared by HOLD, RELEASE and ASSERT.
- The FSM, index register and cause register live in the top level.

## Test plan
All scenarios use P_DOMAINS = 4, P_REQS = 3, P_HOLD = 16, P_DELAY = 100.

1. Power-up: hold RESET high for 5 cycles, then drop it.
   - DOMAIN_RESET_N goes 0001 after 16 cycles, then 0011, 0111 and 1111 at 100-cycle spacing.
   - SEQ_DONE rises with 1111.
2. In RUN, pulse RST_REQ[1] for 1 cycle.
   - DOMAIN_RESET_N goes 0111 on the next cycle, then 0011, 0001 and 0000 at 100-cycle spacing.
   - After 16 cycles of HOLD the domains re-release; RST_CAUSE = 3'b010.
3. Hold RST_REQ[2] high for 50 cycles during HOLD.
   - DOMAIN_RESET_N stays 0000.
   - Domain 0 releases 16 cycles after RST_REQ[2] drops.
4. Raise RST_REQ[0] while DOMAIN_RESET_N = 0011 in RELEASE.
   - Next cycle 0001, then 0000 100 cycles later.
   - Domains 2 and 3 never release.
5. Pulse CAUSE_CLR on the same cycle as RST_REQ[0], with RST_CAUSE = 3'b110 beforehand.
   - RST_CAUSE = 3'b001 on the next cycle.
6. Raise RESET while DOMAIN_RESET_N = 0111.
   - Next edge: DOMAIN_RESET_N = 0000, RST_CAUSE = 0, BUSY = 1, SEQ_DONE = 0.
   - The power-up sequence repeats after RESET drops.
